spi_flash_reader: RTL
=====================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 The block SHALL have parameter CMD_READ, default 8'h03, meaning the read opcode sent as the first byte of every transaction.
REQ-002 The block SHALL have parameter MAX_LEN, default 255, meaning the maximum number of data bytes per request.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(MAX_LEN+5), meaning the width of the byte count presented to the SPI master.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  read request present.
REQ-007 req_addr  input  24  flash byte address.
REQ-008 req_len  input  8  number of data bytes to read (0..MAX_LEN).
REQ-009 req_ready  output  1  block idle and able to accept a request.
REQ-010 rd_valid  output  1  one-cycle pulse, rd_data holds a data byte.
REQ-011 rd_data  output  8  data byte read from flash.
REQ-012 done  output  1  one-cycle pulse at end of a request.
REQ-013 busy  output  1  request in progress.
REQ-014 spi_tx_count  output  CNT_W  bytes per chip-select, to SPI master.
REQ-015 spi_tx_byte  output  8  byte to transmit.
REQ-016 spi_tx_dv  output  1  one-cycle transmit strobe.
REQ-017 spi_tx_ready  input  1  SPI master ready for next byte.
REQ-018 spi_rx_dv  input  1  one-cycle received-byte strobe.
REQ-019 spi_rx_byte  input  8  received byte.

Function
REQ-020 States SHALL be IDLE, CMD, ADDR_HI, ADDR_MID, ADDR_LO, DUMMY, DRAIN, FINISH.
REQ-021 req_ready SHALL be 1 only in IDLE; busy SHALL be the inverse of req_ready.
REQ-022 Acceptance SHALL occur on req_valid & req_ready: latch addr and len, spi_tx_count <= 4 + len (zero-extended to CNT_W), go to CMD if len>0, otherwise go to FINISH.
REQ-023 spi_tx_count SHALL hold its value for the whole transaction.
REQ-024 In each send state, spi_tx_dv SHALL pulse for exactly one cycle when spi_tx_ready=1, with spi_tx_byte valid in the same cycle.
REQ-025 spi_tx_dv SHALL NOT assert in the cycle directly after a spi_tx_dv pulse; this guard cycle is required because the master's ready is combinational on dv.
REQ-026 The byte order SHALL be: CMD sends CMD_READ, ADDR_HI sends addr[23:16], ADDR_MID sends addr[15:8], ADDR_LO sends addr[7:0], then DUMMY sends 8'h00 once per data byte (len strobes).
REQ-027 Each dv pulse SHALL advance the state; DUMMY SHALL decrement a remaining-TX counter and go to DRAIN after the len-th strobe.
REQ-028 An RX counter SHALL count spi_rx_dv strobes in the transaction; the first 4 (header echo) SHALL be discarded.
REQ-029 Strobes 5..len+4 SHALL produce rd_valid=1 with rd_data=spi_rx_byte one cycle after the strobe.
REQ-030 RX counting SHALL be independent of the TX state; strobes arriving in any non-IDLE state SHALL be counted.
REQ-031 DRAIN SHALL wait until the RX counter reaches len+4, then go to FINISH.
REQ-032 FINISH SHALL pulse done for one cycle and return to IDLE; for len=0, done SHALL occur 2 cycles after acceptance with no spi_tx_dv.
REQ-033 There SHALL be no backpressure on rd_valid; the consumer must accept every byte.
REQ-034 req_len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-035 spi_rx_dv in IDLE SHALL be ignored, with no rd_valid produced.
REQ-036 Byte ordering SHALL be preserved: data bytes appear on rd_data in flash address order.

Reset
REQ-037 On rstn=0 at a clock edge: state=IDLE, req_ready=1, busy=0, rd_valid=0, rd_data=0, done=0, spi_tx_dv=0, spi_tx_byte=0, spi_tx_count=0, all counters 0.
REQ-038 Reset mid-transaction SHALL abandon the transaction with no done pulse; the SPI master is reset by the same rstn.

Verification
REQ-039 len=2, addr=24'h123456, model flash returns A5,5A -> SPI MOSI bytes 03,12,34,56,00,00; spi_tx_count=6; rd_data A5 then 5A; one done pulse.
REQ-040 len=0 -> no spi_tx_dv, done pulse 2 cycles after acceptance, req_ready=1 the following cycle.
REQ-041 Back-to-back requests len=1 with req_valid held high -> second accepted only after done; CSn deasserts between transactions.
REQ-042 Check spi_tx_dv every cycle -> never two consecutive cycles high, never high while spi_tx_ready=0.
REQ-043 rstn low during ADDR_MID -> next cycle all outputs at reset values; new request len=1 completes correctly.
REQ-044 len=MAX_LEN (255), addr=0 -> 255 rd_valid pulses in order, spi_tx_count=259.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: issues READ + 24-bit address + dummy bytes to a
// byte-level SPI master and forwards the returned data bytes in address order.
module spi_flash_reader #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int         MAX_LEN  = 255,
    parameter int         CNT_W    = $clog2(MAX_LEN + 5)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    input  logic [23:0]      req_addr,
    input  logic [7:0]       req_len,
    output logic             req_ready,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] spi_tx_count,
    output logic [7:0]       spi_tx_byte,
    output logic             spi_tx_dv,
    input  logic             spi_tx_ready,
    input  logic             spi_rx_dv,
    input  logic [7:0]       spi_rx_byte
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_MID, ADDR_LO, DUMMY, DRAIN, FINISH
    } state_t;

    state_t           state_reg, state_next;
    logic [23:0]      addr_reg;
    logic [7:0]       len_reg;
    logic [7:0]       tx_rem_reg;
    logic [CNT_W-1:0] rx_cnt_reg;
    logic [CNT_W-1:0] count_reg;
    logic             guard_reg;
    logic             done_reg;
    logic             rd_valid_reg;
    logic [7:0]       rd_data_reg;

    logic             accept;
    logic             can_send;
    logic [7:0]       len_clamped;
    logic [CNT_W-1:0] rx_total;

    assign req_ready    = (state_reg == IDLE);
    assign busy         = ~req_ready;
    assign accept       = req_valid && req_ready;
    assign len_clamped  = (int'(req_len) > MAX_LEN) ? 8'(MAX_LEN) : req_len;
    assign rx_total     = CNT_W'(len_reg) + CNT_W'(4);
    // The master's ready reacts combinationally to dv, so skip the cycle after a strobe.
    assign can_send     = spi_tx_ready && !guard_reg;

    assign spi_tx_count = count_reg;
    assign done         = done_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        spi_tx_dv   = 1'b0;
        spi_tx_byte = 8'h00;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (len_clamped != 8'd0) ? CMD : FINISH;
                end
            end
            CMD: begin
                spi_tx_byte = CMD_READ;
                spi_tx_dv   = can_send;
                if (can_send) state_next = ADDR_HI;
            end
            ADDR_HI: begin
                spi_tx_byte = addr_reg[23:16];
                spi_tx_dv   = can_send;
                if (can_send) state_next = ADDR_MID;
            end
            ADDR_MID: begin
                spi_tx_byte = addr_reg[15:8];
                spi_tx_dv   = can_send;
                if (can_send) state_next = ADDR_LO;
            end
            ADDR_LO: begin
                spi_tx_byte = addr_reg[7:0];
                spi_tx_dv   = can_send;
                if (can_send) state_next = DUMMY;
            end
            DUMMY: begin
                spi_tx_dv = can_send;
                if (can_send && tx_rem_reg == 8'd1) state_next = DRAIN;
            end
            DRAIN: begin
                if (rx_cnt_reg == rx_total) state_next = FINISH;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            tx_rem_reg   <= '0;
            rx_cnt_reg   <= '0;
            count_reg    <= '0;
            guard_reg    <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            guard_reg    <= spi_tx_dv;
            done_reg     <= (state_reg == FINISH);
            rd_valid_reg <= 1'b0;

            if (accept) begin
                addr_reg   <= req_addr;
                len_reg    <= len_clamped;
                tx_rem_reg <= len_clamped;
                rx_cnt_reg <= '0;
                count_reg  <= CNT_W'(len_clamped) + CNT_W'(4);
            end else if (state_reg != IDLE && spi_rx_dv) begin
                rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
                // First four received bytes are the echo of command and address.
                if (rx_cnt_reg >= CNT_W'(4) && rx_cnt_reg < rx_total) begin
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= spi_rx_byte;
                end
            end

            if (state_reg == DUMMY && spi_tx_dv) begin
                tx_rem_reg <= tx_rem_reg - 8'd1;
            end
        end
    end

endmodule
